// File: rtl/nyancat_frame_loader.sv
// nyancat_frame_loader
//
// Write-side loader for the nyancat renderer memories. A byte stream comes in
// over a valid/ready handshake. The first PAL_DEPTH bytes fill the palette
// RAM (low 6 bits, RRGGBB). Each later byte carries two 4-bit character
// indices: the low nibble goes to the even frame address and the high nibble
// to the next odd address, one cycle apart.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one trailing byte C follows the frame data. The 8-bit sum of
//   all payload bytes plus C must be zero. Otherwise err is raised together
//   with done. When undefined, there is no trailing byte and err is tied to 0.
//
// Ports
//   px_clk            single clock, rising edge
//   reset             synchronous, active-high
//   start             one-cycle pulse; begins a load when not busy
//   in_valid/in_data  byte source (8 bits)
//   in_ready          loader accepts in_data this cycle
//   pal_we/pal_addr/pal_wdata   palette write port (4-bit addr, 6-bit data)
//   fb_we/fb_addr/fb_wdata      frame RAM write port (FB_ADDR_W addr, 4-bit data)
//   busy              load in progress
//   done              last load completed; held until next start or reset
//   err               checksum mismatch on the last load
//
// All outputs are registered. A write strobe appears one cycle after the
// byte that produced it was accepted.

module nyancat_frame_loader #(
  parameter int NUM_FRAMES = 12,
  parameter int FRAME_W    = 64,
  parameter int FRAME_H    = 64,
  parameter int PAL_DEPTH  = 16,
  localparam int FB_DEPTH   = NUM_FRAMES * FRAME_W * FRAME_H,
  localparam int FB_ADDR_W  = $clog2(FB_DEPTH),
  localparam int PAL_ADDR_W = $clog2(PAL_DEPTH)
) (
  input  logic                  px_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  pal_we,
  output logic [PAL_ADDR_W-1:0] pal_addr,
  output logic [5:0]            pal_wdata,
  output logic                  fb_we,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [3:0]            fb_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Even base address of the final low/high nibble pair.
  localparam logic [FB_ADDR_W-1:0] LAST_PAIR = FB_ADDR_W'(FB_DEPTH - 2);
  localparam logic [PAL_ADDR_W-1:0] PAL_LAST = PAL_ADDR_W'(PAL_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PAL    = 3'd1,
    S_FRM_LO = 3'd2,
    S_FRM_HI = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CHK    = 3'd4,
`endif
    S_DONE   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [PAL_ADDR_W-1:0] pal_cnt_q, pal_cnt_d;
  logic [FB_ADDR_W-1:0]  fb_base_q, fb_base_d;   // even address of current pair
  logic [3:0]            hi_nib_q, hi_nib_d;     // high nibble held for FRM_HI
  logic                  in_ready_q, in_ready_d;
  logic                  pal_we_q, pal_we_d;
  logic [PAL_ADDR_W-1:0] pal_addr_q, pal_addr_d;
  logic [5:0]            pal_wdata_q, pal_wdata_d;
  logic                  fb_we_q, fb_we_d;
  logic [FB_ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [3:0]            fb_wdata_q, fb_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
  logic                  err_q, err_d;
  logic [7:0]            sum_total;
`endif

  logic accept;

  // in_ready is registered, so the handshake is decided by the value the
  // source sees this cycle.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    pal_cnt_d   = pal_cnt_q;
    fb_base_d   = fb_base_q;
    hi_nib_d    = hi_nib_q;
    in_ready_d  = in_ready_q;
    pal_we_d    = 1'b0;
    pal_addr_d  = pal_addr_q;
    pal_wdata_d = pal_wdata_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_wdata_d  = fb_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
    sum_total   = sum_q + in_data;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_PAL;
          pal_cnt_d  = '0;
          fb_base_d  = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = '0;
          err_d      = 1'b0;
`endif
        end
      end

      S_PAL: begin
        if (accept) begin
          pal_we_d    = 1'b1;
          pal_addr_d  = pal_cnt_q;
          pal_wdata_d = in_data[5:0];
          pal_cnt_d   = pal_cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_total;
`endif
          if (pal_cnt_q == PAL_LAST) begin
            state_d = S_FRM_LO;
          end
        end
      end

      S_FRM_LO: begin
        if (accept) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = fb_base_q;
          fb_wdata_d = in_data[3:0];
          hi_nib_d   = in_data[7:4];
          in_ready_d = 1'b0;        // the high nibble needs the next cycle
          state_d    = S_FRM_HI;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = sum_total;
`endif
        end
      end

      S_FRM_HI: begin
        fb_we_d    = 1'b1;
        fb_addr_d  = fb_base_q | FB_ADDR_W'(1);
        fb_wdata_d = hi_nib_q;
        if (fb_base_q == LAST_PAIR) begin
          // Base is not advanced here so it never points past the memory.
`ifdef LOADER_CHECKSUM_EN
          state_d    = S_CHK;
          in_ready_d = 1'b1;
`else
          state_d    = S_DONE;
          in_ready_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
`endif
        end else begin
          fb_base_d  = fb_base_q + FB_ADDR_W'(2);
          state_d    = S_FRM_LO;
          in_ready_d = 1'b1;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          sum_d      = sum_total;
          err_d      = (sum_total != 8'd0);
          in_ready_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end
`endif

      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pal_cnt_q   <= '0;
      fb_base_q   <= '0;
      hi_nib_q    <= '0;
      in_ready_q  <= 1'b0;
      pal_we_q    <= 1'b0;
      pal_addr_q  <= '0;
      pal_wdata_q <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pal_cnt_q   <= pal_cnt_d;
      fb_base_q   <= fb_base_d;
      hi_nib_q    <= hi_nib_d;
      in_ready_q  <= in_ready_d;
      pal_we_q    <= pal_we_d;
      pal_addr_q  <= pal_addr_d;
      pal_wdata_q <= pal_wdata_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign pal_we    = pal_we_q;
  assign pal_addr  = pal_addr_q;
  assign pal_wdata = pal_wdata_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_nyancat_frame_loader.sv
// Testbench for nyancat_frame_loader (reduced memory size: 3 frames of 16x8).
// A count-based reference model predicts every registered output for the
// next cycle; a compare process checks it on each falling edge. Memory images
// captured from the write ports are compared against the byte stream sent.
// Honours LOADER_CHECKSUM_EN the same way as the design.

module tb_nyancat_frame_loader;
  localparam int NF  = 3;
  localparam int FW  = 16;
  localparam int FH  = 8;
  localparam int PD  = 16;
  localparam int FBD = NF * FW * FH;       // 384
  localparam int FAW = $clog2(FBD);        // 9
  localparam int P   = PD + FBD / 2;       // payload bytes
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic           px_clk = 1'b0;
  logic           reset;
  logic           start;
  logic           in_valid;
  logic [7:0]     in_data;
  logic           in_ready;
  logic           pal_we;
  logic [3:0]     pal_addr;
  logic [5:0]     pal_wdata;
  logic           fb_we;
  logic [FAW-1:0] fb_addr;
  logic [3:0]     fb_wdata;
  logic           busy;
  logic           done;
  logic           err;

  nyancat_frame_loader #(
    .NUM_FRAMES(NF), .FRAME_W(FW), .FRAME_H(FH), .PAL_DEPTH(PD)
  ) dut (
    .px_clk(px_clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 px_clk = ~px_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (predicts next-cycle outputs) ----------
  logic           m_ready = 0, m_busy = 0, m_done = 0, m_err = 0;
  logic           m_pal_we = 0, m_fb_we = 0;
  logic [3:0]     m_pal_addr = 0;
  logic [5:0]     m_pal_wdata = 0;
  logic [FAW-1:0] m_fb_addr = 0;
  logic [3:0]     m_fb_wdata = 0;
  logic [3:0]     m_pend_data = 0;
  logic [7:0]     m_sum = 0;
  int             m_n = 0, m_pend_addr = 0;
  bit             m_pend = 0, m_live = 0, m_rst = 0;

  always @(posedge px_clk) begin
    int k;
    m_rst = reset;
    if (reset) begin
      m_live = 1; m_ready = 0; m_busy = 0; m_done = 0; m_err = 0;
      m_pal_we = 0; m_fb_we = 0; m_pal_addr = 0; m_pal_wdata = 0;
      m_fb_addr = 0; m_fb_wdata = 0; m_pend = 0; m_n = 0; m_sum = 0;
    end else begin
      m_pal_we = 0;
      m_fb_we  = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_done = 0; m_err = 0; m_n = 0; m_sum = 0; m_ready = 1;
        end
      end else if (m_pend) begin
        m_fb_we = 1; m_fb_addr = FAW'(m_pend_addr); m_fb_wdata = m_pend_data;
        m_pend = 0;
        if (m_n < P || CK) m_ready = 1;
        else begin m_busy = 0; m_done = 1; m_ready = 0; end
      end else if (in_valid && m_ready) begin
        m_sum = m_sum + in_data;
        if (m_n < PD) begin
          m_pal_we = 1; m_pal_addr = 4'(m_n); m_pal_wdata = in_data[5:0];
        end else if (m_n < P) begin
          k = m_n - PD;
          m_fb_we = 1; m_fb_addr = FAW'(2 * k); m_fb_wdata = in_data[3:0];
          m_pend = 1; m_pend_addr = 2 * k + 1; m_pend_data = in_data[7:4];
          m_ready = 0;
        end else begin
          m_err = (m_sum != 8'd0); m_busy = 0; m_done = 1; m_ready = 0;
        end
        m_n++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge px_clk) begin
    if (m_live) begin
      chk("in_ready", in_ready, m_ready);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("pal_we", pal_we, m_pal_we);
      chk("fb_we", fb_we, m_fb_we);
      if (m_pal_we || m_rst) begin
        chk("pal_addr", pal_addr, m_pal_addr);
        chk("pal_wdata", pal_wdata, m_pal_wdata);
      end
      if (m_fb_we || m_rst) begin
        chk("fb_addr", fb_addr, m_fb_addr);
        chk("fb_wdata", fb_wdata, m_fb_wdata);
      end
    end
  end

  // ---------------- memory capture ----------------
  logic [5:0] pal_img [PD];
  logic [3:0] fb_img  [FBD];
  int fb_we_cnt = 0;
  int oob_cnt   = 0;

  always @(negedge px_clk) begin
    if (pal_we === 1'b1) pal_img[pal_addr] = pal_wdata;
    if (fb_we === 1'b1) begin
      fb_we_cnt++;
      if (int'(fb_addr) >= FBD) oob_cnt++;
      else fb_img[fb_addr] = fb_wdata;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] stream [$];
  logic [5:0] exp_pal [PD];
  logic [3:0] exp_fb  [FBD];

  task automatic make_stream(input bit fixed, input bit corrupt);
    logic [7:0] b;
    logic [7:0] s;
    s = 8'd0;
    stream.delete();
    for (int i = 0; i < PD; i++) begin
      b = fixed ? 8'(i) : 8'($urandom);
      stream.push_back(b); s = s + b; exp_pal[i] = b[5:0];
    end
    for (int k = 0; k < FBD / 2; k++) begin
      b = (fixed && k == 0) ? 8'hA5 : 8'($urandom);
      stream.push_back(b); s = s + b;
      exp_fb[2 * k] = b[3:0]; exp_fb[2 * k + 1] = b[7:4];
    end
    if (CK) stream.push_back(8'(8'd0 - s) + 8'(corrupt));
  endtask

  task automatic run_load(input int stall_pct, input int abort_at,
                          input bit poke_start, input bit exp_err);
    int idx, cyc, base_we, base_oob, bad_p, bad_f;
    bit v, acc;
    base_we = fb_we_cnt; base_oob = oob_cnt;
    @(negedge px_clk);
    start = 1; in_valid = 0;
    @(negedge px_clk);
    start = 0;
    idx = 0; cyc = 0;
    while (idx < stream.size() && cyc < 5000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      v = ($urandom_range(99) >= stall_pct);
      in_valid = v;
      in_data  = v ? stream[idx] : 8'($urandom);
      start    = poke_start && (idx == PD + 3);
      acc      = v && (in_ready === 1'b1);
      @(negedge px_clk);
      cyc++;
      if (acc) idx++;
    end
    in_valid = 0; start = 0;
    if (abort_at >= 0) begin
      reset = 1;
      repeat (2) @(negedge px_clk);
      reset = 0;
      chk("abort_idx", idx, abort_at);
      chk("abort_busy", busy, 0);
      return;
    end
    while (done !== 1'b1 && cyc < 5000) begin
      @(negedge px_clk);
      cyc++;
    end
    chk("load_done", done, 1);
    @(negedge px_clk);
    #1;
    chk("busy_after", busy, 0);
    chk("err_final", err, exp_err);
    chk("fb_we_count", fb_we_cnt - base_we, FBD);
    chk("final_fb_addr", fb_addr, FBD - 1);
    chk("out_of_range", oob_cnt - base_oob, 0);
    bad_p = 0; bad_f = 0;
    for (int i = 0; i < PD; i++)  if (pal_img[i] !== exp_pal[i]) bad_p++;
    for (int i = 0; i < FBD; i++) if (fb_img[i] !== exp_fb[i]) bad_f++;
    chk("pal_image_bad", bad_p, 0);
    chk("fb_image_bad", bad_f, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; in_valid = 1; in_data = 8'h5A;
    repeat (3) @(negedge px_clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_strobes", {pal_we, fb_we}, 0);
    chk("rst_status", {busy, done, err}, 0);
    chk("rst_addrs", {pal_addr, fb_addr}, 0);
    chk("rst_wdata", {pal_wdata, fb_wdata}, 0);
    reset = 0; in_valid = 0;

    // Palette 0x00..0x0F, first frame byte 0xA5, no stalls.
    make_stream(1'b1, 1'b0);
    run_load(0, -1, 1'b0, 1'b0);
    chk("pal_img3", pal_img[3], 6'h03);
    chk("pal_img15", pal_img[15], 6'h0F);
    chk("fb_img0", fb_img[0], 4'h5);
    chk("fb_img1", fb_img[1], 4'hA);

    // Random data, heavy stalls, start pulsed while busy.
    make_stream(1'b0, 1'b0);
    run_load(30, -1, 1'b1, 1'b0);

    if (CK) begin
      make_stream(1'b0, 1'b1);
      run_load(10, -1, 1'b0, 1'b1);
    end

    // Reset part-way through the frame phase, then a clean full load.
    make_stream(1'b0, 1'b0);
    run_load(20, PD + 40, 1'b0, 1'b0);
    make_stream(1'b0, 1'b0);
    run_load(20, -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nyancat_frame_loader.md
# nyancat_frame_loader

Writer-side counterpart of the animation renderer's memory read path: accepts a byte stream over a valid/ready handshake and writes the palette RAM and the packed 4-bit frame RAM that the renderer later reads. Sits between a byte source (UART receiver, SPI flash reader or testbench) and the write ports of the frame and palette memories. Unpacks two character indices per byte, sequences the palette and frame phases, and reports busy/done/error status.

## Interface
Parameters:
- NUM_FRAMES, 12, number of animation frames
- FRAME_W, 64, source frame width in character cells
- FRAME_H, 64, source frame height
- PAL_DEPTH, 16, palette entries (6-bit RRGGBB each)
- Derived: FB_DEPTH = NUM_FRAMES*FRAME_W*FRAME_H (49152); FB_ADDR_W = $clog2(FB_DEPTH) (16); FB_DEPTH is even.

Ports:
- px_clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a load when not busy
- in_valid  in  1  source has a byte
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts in_data this cycle
- pal_we  out  1  palette write strobe
- pal_addr  out  4  palette index
- pal_wdata  out  6  palette color (in_data[5:0])
- fb_we  out  1  frame memory write strobe
- fb_addr  out  FB_ADDR_W  frame memory address
- fb_wdata  out  4  character index
- busy  out  1  load in progress
- done  out  1  last load completed; held until next start or reset
- err  out  1  checksum mismatch on last load (see Configuration)

## Operation
- States: IDLE, PAL, FRM_LO, FRM_HI, CHK (only with checksum), DONE.
- IDLE/DONE: in_ready=0. start -> PAL; pal counter, fb address, checksum accumulator cleared; done and err cleared in the same edge.
- start while busy: ignored.
- PAL: in_ready=1. Each accepted byte (in_valid && in_ready) registers pal_we=1, pal_addr=count, pal_wdata=in_data[5:0]; bits [7:6] ignored. After PAL_DEPTH accepted bytes -> FRM_LO.
- FRM_LO: in_ready=1. Accepted byte is latched; next cycle fb_we=1, fb_addr=A, fb_wdata=in_data[3:0] (low nibble first = even address); state -> FRM_HI.
- FRM_HI: in_ready=0; fb_we=1, fb_addr=A+1, fb_wdata=latched[7:4]; A += 2. If A+1 == FB_DEPTH-1 -> CHK (or DONE if checksum compiled out), else FRM_LO.
- Total payload: PAL_DEPTH + FB_DEPTH/2 bytes (16 + 24576).
- in_valid low stalls without any write; no byte is ever dropped or duplicated.
- DONE: busy=0, done=1; write strobes 0.
- Address arithmetic unsigned, FB_ADDR_W wide; never written at or beyond FB_DEPTH.

## Timing
- Reset values: in_ready=0, pal_we=0, pal_addr=0, pal_wdata=0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, done=0, err=0; state IDLE.
- All outputs registered. Write strobe is 1 cycle after byte acceptance.
- Palette throughput: 1 byte/cycle. Frame throughput: 1 byte/2 cycles (in_ready low in FRM_HI).
- busy rises the cycle after start; falls the cycle done rises.
- Reset mid-load: next cycle all strobes 0, IDLE, memory contents left partially written (no rollback).
- Renderer reads concurrently are permitted; display shows partial data until done.

## Configuration
- LOADER_CHECKSUM_EN defined: after the last frame byte, CHK accepts one extra byte C (in_ready=1). Accumulator = 8-bit sum of all payload bytes plus C; err=1 if result != 0, set with done. No memory write for C.
- Undefined: no CHK state, no trailing byte, err tied to 0, FRM_HI goes straight to DONE.

## Test plan
- Reset: hold reset 3 cycles with in_valid=1 -> all outputs 0, in_ready=0, no strobes.
- Palette load: start, bytes 0x00..0x0F continuous -> 16 pal_we pulses, pal_addr 0..15, pal_wdata = byte[5:0], one per cycle.
- Frame unpack: first frame byte 0xA5 -> fb_we at addr 0 data 5, then addr 1 data 0xA; in_ready low for exactly that second cycle.
- Backpressure/stall: random in_valid gaps over full 24592-byte load -> exactly 49152 fb_we pulses, final fb_addr 49151, done=1, busy=0.
- Checksum (macro on): correct trailing byte -> err=0; corrupted by +1 -> err=1 with done.
- Reset at byte 1000 of frames, then start and full load -> clean restart from pal_addr 0, correct final memory image.
